// File: rtl/uart_comm_pkg.sv
// ============================================================================
// Module      : uart_comm_pkg
// Description : Shared types, ASCII constants and the wheel-speed frame
//               formatter for the rover motor-command UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_comm_pkg;

    // 11-byte prefix + 5-byte ",\"R\":" + 2-byte tail + two 3..4 byte values
    localparam int              MAX_FRAME_LEN = 26;
    localparam int              LEN_W         = 5;
    localparam logic [3:0]      SPEED_MAX     = 4'd10;

    localparam logic [7:0] c_lbrace = 8'h7B;
    localparam logic [7:0] c_rbrace = 8'h7D;
    localparam logic [7:0] c_quote  = 8'h22;
    localparam logic [7:0] c_colon  = 8'h3A;
    localparam logic [7:0] c_comma  = 8'h2C;
    localparam logic [7:0] c_minus  = 8'h2D;
    localparam logic [7:0] c_dot    = 8'h2E;
    localparam logic [7:0] c_zero   = 8'h30;
    localparam logic [7:0] c_one    = 8'h31;
    localparam logic [7:0] c_t      = 8'h54;
    localparam logic [7:0] c_l      = 8'h4C;
    localparam logic [7:0] c_r      = 8'h52;
    localparam logic [7:0] c_lf     = 8'h0A;

    typedef enum logic [3:0] {
        STOP   = 4'd0,
        FWD    = 4'd1,
        RIGHT  = 4'd2,
        LEFT   = 4'd3,
        BACK   = 4'd4,
        SPIN_R = 4'd5,
        SPIN_L = 4'd6
    } move_cmd_e;

    typedef enum logic [1:0] {
        DIR_ZERO = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } wheel_dir_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        FR_IDLE  = 2'd0,
        FR_BUILD = 2'd1,
        FR_SEND  = 2'd2
    } frame_state_e;

    typedef logic [MAX_FRAME_LEN-1:0][7:0] frame_bytes_t;

    typedef struct packed {
        frame_bytes_t       bytes;
        logic [LEN_W-1:0]   len;
    } frame_t;

    typedef struct packed {
        logic [3:0][7:0]    ch;
        logic [2:0]         n;
    } val_text_t;

    // s is already clamped to 0..SPEED_MAX; a zero magnitude never gets a sign
    function automatic val_text_t value_text(input wheel_dir_e dir, input logic [3:0] s);
        val_text_t  t;
        logic [7:0] d1;
        logic [7:0] d0;
        t  = '0;
        d1 = (s == SPEED_MAX) ? c_one  : c_zero;
        d0 = (s == SPEED_MAX) ? c_zero : (c_zero + {4'h0, s});
        if ((dir == DIR_ZERO) || (s == 4'd0)) begin
            t.ch[0] = c_zero;
            t.ch[1] = c_dot;
            t.ch[2] = c_zero;
            t.n     = 3'd3;
        end else if (dir == DIR_NEG) begin
            t.ch[0] = c_minus;
            t.ch[1] = d1;
            t.ch[2] = c_dot;
            t.ch[3] = d0;
            t.n     = 3'd4;
        end else begin
            t.ch[0] = d1;
            t.ch[1] = c_dot;
            t.ch[2] = d0;
            t.n     = 3'd3;
        end
        return t;
    endfunction

    function automatic frame_t format_frame(input logic [3:0] cmd, input logic [3:0] speed);
        frame_t           f;
        logic [3:0]       s;
        wheel_dir_e       dl;
        wheel_dir_e       dr;
        val_text_t        vl;
        val_text_t        vr;
        logic [LEN_W-1:0] p;
        f  = '0;
        s  = (speed > SPEED_MAX) ? SPEED_MAX : speed;
        dl = DIR_ZERO;
        dr = DIR_ZERO;
        case (cmd)
            FWD:     begin dl = DIR_POS; dr = DIR_POS; end
            RIGHT:   begin dl = DIR_POS; dr = DIR_ZERO; end
            LEFT:    begin dl = DIR_ZERO; dr = DIR_POS; end
            BACK:    begin dl = DIR_NEG; dr = DIR_NEG; end
            SPIN_R:  begin dl = DIR_POS; dr = DIR_NEG; end
            SPIN_L:  begin dl = DIR_NEG; dr = DIR_POS; end
            default: begin dl = DIR_ZERO; dr = DIR_ZERO; end
        endcase
        vl = value_text(dl, s);
        vr = value_text(dr, s);

        f.bytes[0]  = c_lbrace;
        f.bytes[1]  = c_quote;
        f.bytes[2]  = c_t;
        f.bytes[3]  = c_quote;
        f.bytes[4]  = c_colon;
        f.bytes[5]  = c_one;
        f.bytes[6]  = c_comma;
        f.bytes[7]  = c_quote;
        f.bytes[8]  = c_l;
        f.bytes[9]  = c_quote;
        f.bytes[10] = c_colon;
        p = LEN_W'(11);
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < vl.n) f.bytes[p + LEN_W'(i)] = vl.ch[2'(i)];
        end
        p = p + {2'b00, vl.n};
        f.bytes[p]              = c_comma;
        f.bytes[p + LEN_W'(1)]  = c_quote;
        f.bytes[p + LEN_W'(2)]  = c_r;
        f.bytes[p + LEN_W'(3)]  = c_quote;
        f.bytes[p + LEN_W'(4)]  = c_colon;
        p = p + LEN_W'(5);
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < vr.n) f.bytes[p + LEN_W'(i)] = vr.ch[2'(i)];
        end
        p = p + {2'b00, vr.n};
        f.bytes[p]             = c_rbrace;
        f.bytes[p + LEN_W'(1)] = c_lf;
        f.len = p + LEN_W'(2);
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer, LSB first; accepts the next byte in the
//               last stop-bit cycle so consecutive bytes have no gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
    import uart_comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int               CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             w_bit_end;
    logic             w_load;

    assign w_bit_end = (cnt_q == c_last_cnt);
    assign busy      = (state_q != TX_IDLE);
    assign done      = (state_q == TX_STOP) && w_bit_end;
    assign w_load    = start && (!busy || done);
    assign tx        = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        if (busy) cnt_d = w_bit_end ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            TX_IDLE: tx_d = 1'b1;
            TX_START: begin
                if (w_bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        // A load overrides the stop-bit exit so the next start bit follows directly
        if (w_load) begin
            state_d = TX_START;
            cnt_d   = '0;
            shreg_d = data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_comm.sv
// ============================================================================
// Module      : uart_comm
// Description : Motor-command UART transmitter; formats a JSON wheel-speed
//               frame from move/speed inputs and sends it 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] move_cmd,
    input  logic [3:0] speed_level,
    input  logic       valid,
    output logic       ready,
    output logic       uart_out
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    frame_state_e     state_q, state_d;
    logic             ready_q, ready_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [3:0]       speed_q, speed_d;
    frame_t           frame_q, frame_d;
    logic [LEN_W-1:0] idx_q, idx_d;

    frame_t           w_frame;
    logic             w_tx_start;
    logic [7:0]       w_tx_data;
    logic             w_tx_busy;
    logic             w_tx_done;

    assign w_frame = format_frame(cmd_q, speed_q);
    assign ready   = ready_q;

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        cmd_d      = cmd_q;
        speed_d    = speed_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        w_tx_start = 1'b0;
        w_tx_data  = frame_q.bytes[idx_q];
        case (state_q)
            FR_IDLE: begin
                ready_d = 1'b1;
                if (valid && ready_q) begin
                    cmd_d   = move_cmd;
                    speed_d = speed_level;
                    ready_d = 1'b0;
                    state_d = FR_BUILD;
                end
            end
            FR_BUILD: begin
                // Byte 0 goes straight from the formatter so its start bit is not delayed
                frame_d    = w_frame;
                idx_d      = '0;
                w_tx_start = !w_tx_busy;
                w_tx_data  = w_frame.bytes[0];
                state_d    = FR_SEND;
            end
            FR_SEND: begin
                if (w_tx_done) begin
                    if (idx_q == frame_q.len - LEN_W'(1)) begin
                        state_d = FR_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + LEN_W'(1);
                        w_tx_start = 1'b1;
                        w_tx_data  = frame_q.bytes[idx_q + LEN_W'(1)];
                    end
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FR_IDLE;
            ready_q <= 1'b0;
            cmd_q   <= '0;
            speed_q <= '0;
            frame_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cmd_q   <= cmd_d;
            speed_q <= speed_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (w_tx_start),
        .data  (w_tx_data),
        .busy  (w_tx_busy),
        .done  (w_tx_done),
        .tx    (uart_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_comm.sv
// ============================================================================
// Module      : tb_uart_comm
// Description : Self-checking bench for uart_comm with a model UART receiver
//               and a string-level reference frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_comm;

    localparam int CPB      = 10;
    localparam int BYTE_CYC = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] move_cmd = '0;
    logic [3:0] speed_level = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic       uart_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] cmd;
        logic [3:0] spd;
        string      exp;
    } vec_t;

    vec_t vecs[7];

    uart_comm #(
        .CLK_FREQ (50_000_000),
        .BAUD     (5_000_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .move_cmd    (move_cmd),
        .speed_level (speed_level),
        .valid       (valid),
        .ready       (ready),
        .uart_out    (uart_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic string printable(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else               r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" required \"%s\"", name, printable(act), printable(exp));
        end
    endtask

    function automatic string val_str(input int v);
        int a;
        if (v == 0) return "0.0";
        a = (v < 0) ? -v : v;
        if (v < 0) return $sformatf("-%0d.%0d", a / 10, a % 10);
        return $sformatf("%0d.%0d", a / 10, a % 10);
    endfunction

    // Reference: wheel speeds as signed tenths, rendered as text
    function automatic string model_frame(input int cmd, input int spd);
        int s;
        int l;
        int r;
        s = (spd > 10) ? 10 : spd;
        l = 0;
        r = 0;
        case (cmd)
            1: begin l = s;  r = s;  end
            2: begin l = s;  r = 0;  end
            3: begin l = 0;  r = s;  end
            4: begin l = -s; r = -s; end
            5: begin l = s;  r = -s; end
            6: begin l = -s; r = s;  end
            default: begin l = 0; r = 0; end
        endcase
        return {"{\"T\":1,\"L\":", val_str(l), ",\"R\":", val_str(r), "}\n"};
    endfunction

    // Called at a negedge; returns at the stop-bit centre negedge
    task automatic rx_byte(output logic [7:0] b, output bit timed_out, output bit bad, output int t0);
        int n = 0;
        b = '0; timed_out = 1'b0; bad = 1'b0; t0 = 0;
        while (uart_out !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (uart_out !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (uart_out !== 1'b0) bad = 1'b1;
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = uart_out;
        end
        repeat (CPB) @(negedge clk);
        if (uart_out !== 1'b1) bad = 1'b1;
    endtask

    task automatic rx_frame(input string exp, input string tag);
        string      got = "";
        int         nb = 0;
        int         bad_gap = 0;
        int         bad_frm = 0;
        int         prev = 0;
        int         t0;
        logic [7:0] b;
        bit         to;
        bit         bad;
        bit         timeout = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rx_byte(b, to, bad, t0);
            if (to) begin
                timeout = 1'b1;
                break;
            end
            if (bad) bad_frm++;
            if (nb > 0 && (t0 - prev) != BYTE_CYC) bad_gap++;
            prev = t0;
            got  = {got, $sformatf("%c", b)};
            nb++;
            if (b == 8'h0A) break;
        end
        chk({"rx_timeout_", tag}, timeout, 0);
        chk_str({"frame_", tag}, got, exp);
        chk({"frame_len_", tag}, nb, exp.len());
        chk({"byte_gap_", tag}, bad_gap, 0);
        chk({"framing_", tag}, bad_frm, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({"ready_wait_", tag}, ready, 1);
    endtask

    // Leaves the caller at the negedge of the first start-bit cycle
    task automatic start_frame(input logic [3:0] cmd, input logic [3:0] spd, input bit hold, input string tag);
        wait_ready(tag);
        move_cmd    = cmd;
        speed_level = spd;
        valid       = 1'b1;
        @(negedge clk);
        if (!hold) valid = 1'b0;
        chk({"ready_drop_", tag}, ready, 0);
        chk({"build_idle_", tag}, uart_out, 1);
        @(negedge clk);
        chk({"start_latency_", tag}, uart_out, 0);
    endtask

    task automatic end_ready(input bit held, input string tag);
        repeat (4) @(negedge clk);
        chk({"ready_in_stop_", tag}, ready, 0);
        @(negedge clk);
        chk({"ready_return_", tag}, ready, 1);
        if (held) begin
            @(negedge clk);
            chk({"ready_one_cycle_", tag}, ready, 0);
        end
    endtask

    task automatic idle_check(input string tag);
        int bad = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (uart_out !== 1'b1 || ready !== 1'b1) bad++;
        end
        chk({"idle_", tag}, bad, 0);
    endtask

    initial begin
        vecs[0] = '{4'd1, 4'd2,  "{\"T\":1,\"L\":0.2,\"R\":0.2}\n"};
        vecs[1] = '{4'd2, 4'd10, "{\"T\":1,\"L\":1.0,\"R\":0.0}\n"};
        vecs[2] = '{4'd6, 4'd5,  "{\"T\":1,\"L\":-0.5,\"R\":0.5}\n"};
        vecs[3] = '{4'd4, 4'd15, "{\"T\":1,\"L\":-1.0,\"R\":-1.0}\n"};
        vecs[4] = '{4'd9, 4'd7,  "{\"T\":1,\"L\":0.0,\"R\":0.0}\n"};
        vecs[5] = '{4'd5, 4'd1,  "{\"T\":1,\"L\":0.1,\"R\":-0.1}\n"};
        vecs[6] = '{4'd3, 4'd0,  "{\"T\":1,\"L\":0.0,\"R\":0.0}\n"};

        repeat (100) @(negedge clk);
        chk("rst_uart_out", uart_out, 1);
        chk("rst_ready", ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready, 1);

        // Table vectors; a valid pulse mid-frame must be ignored
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            start_frame(vecs[i].cmd, vecs[i].spd, 1'b0, tag);
            fork
                rx_frame(vecs[i].exp, tag);
                begin
                    repeat (50) @(negedge clk);
                    move_cmd    = ~vecs[i].cmd;
                    speed_level = 4'($urandom_range(0, 15));
                    valid       = 1'b1;
                    @(negedge clk);
                    valid       = 1'b0;
                end
            join
            end_ready(1'b0, tag);
            idle_check(tag);
        end

        for (int i = 0; i < 5; i++) begin
            int    c;
            int    s;
            string tag;
            c   = $urandom_range(0, 15);
            s   = $urandom_range(0, 15);
            tag = $sformatf("rnd%0d_c%0d_s%0d", i, c, s);
            start_frame(4'(c), 4'(s), 1'b0, tag);
            rx_frame(model_frame(c, s), tag);
            end_ready(1'b0, tag);
        end

        // Back-to-back with valid held and the command changed mid-frame
        start_frame(4'd1, 4'd3, 1'b1, "b2b0");
        fork
            rx_frame(model_frame(1, 3), "b2b0");
            begin
                repeat (300) @(negedge clk);
                move_cmd    = 4'd5;
                speed_level = 4'd4;
            end
        join
        end_ready(1'b1, "b2b0");
        valid = 1'b0;
        rx_frame(model_frame(5, 4), "b2b1");
        end_ready(1'b0, "b2b1");

        // Asynchronous reset in the middle of a low bit
        start_frame(4'd1, 4'd9, 1'b0, "abort");
        repeat (150) @(negedge clk);
        for (int n = 0; n < 50 && uart_out !== 1'b0; n++) @(negedge clk);
        chk("pre_reset_low", uart_out, 0);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_uart_out", uart_out, 1);
        chk("rst_async_ready", ready, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", ready, 1);
        idle_check("after_abort");
        start_frame(4'd3, 4'd7, 1'b0, "clean");
        rx_frame(model_frame(3, 7), "clean");
        end_ready(1'b0, "clean");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
